// File: rtl/dbpsk_frame_serializer.sv
// Serializes preamble, sync word, length, payload and CRC-8 MSB-first, one bit per clock,
// into the DBPSK modulator's data/trigger inputs. Payload bytes arrive over a valid/ready handshake.
module dbpsk_frame_serializer #(
    parameter int          PREAMBLE_BITS = 16,
    parameter logic [7:0]  SYNC_WORD     = 8'hD3,
    parameter logic [7:0]  CRC_POLY      = 8'h07
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] frame_len,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       output_bit,
    output logic       output_en,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SYNC,
        S_LEN,
        S_PAY,
        S_CRC
    } state_t;

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_BITS - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [6:0]  r_shift;
    logic [7:0]  r_len;
    logic [7:0]  r_bytes_left;
    logic [7:0]  r_crc;
    logic        r_out_bit;
    logic        r_out_en;
    logic        r_busy;
    logic        r_done;
    logic        r_underrun;
    logic        r_s_ready;

    // CRC register as it will be after absorbing the bit on the line this cycle
    logic        w_fb;
    logic [7:0]  w_crc_next;
    logic        w_in_crc_field;
    logic        w_last_field_byte;

    assign w_fb           = r_out_bit ^ r_crc[7];
    assign w_crc_next     = {r_crc[6:0], 1'b0} ^ (w_fb ? CRC_POLY : 8'h00);
    assign w_in_crc_field = (r_state == S_LEN) || (r_state == S_PAY);
    assign w_last_field_byte = ((r_state == S_LEN) && (r_len == 8'd0)) ||
                               ((r_state == S_PAY) && (r_bytes_left == 8'd1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_shift      <= 7'd0;
            r_len        <= 8'd0;
            r_bytes_left <= 8'd0;
            r_crc        <= 8'd0;
            r_out_bit    <= 1'b0;
            r_out_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_underrun   <= 1'b0;
            r_s_ready    <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            r_s_ready  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len     <= frame_len;
                        r_crc     <= 8'd0;
                        r_cnt     <= 8'd0;
                        r_state   <= S_PRE;
                        r_out_en  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_out_bit <= 1'b1;
                    end
                end
                S_PRE: begin
                    if (r_cnt == PRE_LAST) begin
                        r_state   <= S_SYNC;
                        r_cnt     <= 8'd0;
                        r_shift   <= SYNC_WORD[6:0];
                        r_out_bit <= SYNC_WORD[7];
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    if (w_in_crc_field)
                        r_crc <= w_crc_next;
                    if (r_cnt != 8'd7) begin
                        r_cnt     <= r_cnt + 8'd1;
                        r_out_bit <= r_shift[6];
                        r_shift   <= {r_shift[5:0], 1'b0};
                        // Request the next byte one bit early so it can follow without a gap
                        if ((r_cnt == 8'd6) && w_in_crc_field && !w_last_field_byte)
                            r_s_ready <= 1'b1;
                    end else begin
                        r_cnt <= 8'd0;
                        if (r_state == S_SYNC) begin
                            r_state   <= S_LEN;
                            r_shift   <= r_len[6:0];
                            r_out_bit <= r_len[7];
                        end else if (r_state == S_CRC) begin
                            r_state   <= S_IDLE;
                            r_out_en  <= 1'b0;
                            r_busy    <= 1'b0;
                            r_out_bit <= 1'b0;
                            r_done    <= 1'b1;
                        end else if (w_last_field_byte) begin
                            r_state   <= S_CRC;
                            r_shift   <= w_crc_next[6:0];
                            r_out_bit <= w_crc_next[7];
                        end else if (r_s_ready && s_valid) begin
                            r_state      <= S_PAY;
                            r_shift      <= s_data[6:0];
                            r_out_bit    <= s_data[7];
                            r_bytes_left <= (r_state == S_LEN) ? r_len : (r_bytes_left - 8'd1);
                        end else begin
                            r_state    <= S_IDLE;
                            r_out_en   <= 1'b0;
                            r_busy     <= 1'b0;
                            r_out_bit  <= 1'b0;
                            r_underrun <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign s_ready    = r_s_ready;
    assign output_bit = r_out_bit;
    assign output_en  = r_out_en;
    assign busy       = r_busy;
    assign done       = r_done;
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_dbpsk_frame_serializer.sv
// Scoreboard bench for dbpsk_frame_serializer: expected per-cycle output vectors are queued
// when a frame is requested and popped/compared every cycle while the frame runs.
module tb_dbpsk_frame_serializer;

    localparam int         P    = 16;
    localparam logic [7:0] SYNC = 8'hD3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] frame_len;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       output_bit;
    logic       output_en;
    logic       busy;
    logic       done;
    logic       underrun;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic hold   = 1'b0;

    logic [5:0] exp_q[$];
    logic [8:0] pay_q[$];
    logic [7:0] pl_buf [0:255];

    always #5 clk = ~clk;

    dbpsk_frame_serializer #(
        .PREAMBLE_BITS(P),
        .SYNC_WORD(SYNC),
        .CRC_POLY(8'h07)
    ) dut (
        .clock(clk),
        .reset(reset),
        .start(start),
        .frame_len(frame_len),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .output_bit(output_bit),
        .output_en(output_en),
        .busy(busy),
        .done(done),
        .underrun(underrun)
    );

    function automatic logic [5:0] outs();
        return {output_en, output_bit, busy, s_ready, done, underrun};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, want);
    endtask

    function automatic logic [7:0] crc8(input logic [7:0] c_in, input logic [7:0] b);
        logic [7:0] c;
        c = c_in ^ b;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    // Queue the expected cycles of one frame; drop>=0 withholds that payload byte
    task automatic push_frame(input int len, input int drop);
        logic       bq[$];
        logic [7:0] c;
        logic [7:0] b;
        logic [7:0] sw;
        logic [7:0] lenb;
        logic       rdy;
        int         k_end;
        c    = 8'h00;
        sw   = SYNC;
        lenb = 8'(len);
        for (int i = 0; i < P; i++) bq.push_back(1'b1);
        for (int i = 7; i >= 0; i--) bq.push_back(sw[i]);
        for (int i = 7; i >= 0; i--) bq.push_back(lenb[i]);
        c = crc8(c, lenb);
        for (int j = 0; j < len; j++) begin
            b = pl_buf[j];
            for (int i = 7; i >= 0; i--) bq.push_back(b[i]);
            c = crc8(c, b);
            if (drop < 0 || j < drop) pay_q.push_back({1'b0, b});
            else if (j == drop) pay_q.push_back(9'h100);
        end
        for (int i = 7; i >= 0; i--) bq.push_back(c[i]);
        k_end = (drop < 0) ? bq.size() - 1 : P + 16 + 8 * drop - 1;
        for (int k = 0; k <= k_end; k++) begin
            rdy = (len > 0) && ((k == P + 15) ||
                  (k >= P + 16 && k < P + 16 + 8 * (len - 1) && ((k - P - 16) % 8) == 7));
            exp_q.push_back({1'b1, bq[k], 1'b1, rdy, 1'b0, 1'b0});
        end
        exp_q.push_back((drop < 0) ? 6'b000010 : 6'b000001);
        $display("frame len=%0d drop=%0d crc=%02h cycles=%0d", len, drop, c, k_end + 1);
    endtask

    task automatic run(input int max_cycles);
        logic [5:0] rec;
        logic [8:0] e;
        int         n;
        n = 0;
        while (exp_q.size() > 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
            cyc++;
            rec = exp_q.pop_front();
            chk("cycle", 32'(outs()), 32'(rec));
            if (!hold || exp_q.size() == 0) start = 1'b0;
            if (!hold) frame_len = 8'($urandom);
            if (s_ready && pay_q.size() > 0) begin
                e       = pay_q.pop_front();
                s_valid = !e[8];
                s_data  = e[7:0];
            end else begin
                s_valid = 1'($urandom);
                s_data  = 8'($urandom);
            end
        end
        if (max_cycles > 1000) chk("timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic idle_chk(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            chk("idle", 32'(outs()), 32'd0);
            s_valid = 1'($urandom);
            s_data  = 8'($urandom);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; frame_len = 8'd0; s_data = 8'd0; s_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            cyc++;
            chk("reset", 32'(outs()), 32'd0);
        end
        reset = 1'b0;
        idle_chk(2);

        // empty payload
        start = 1'b1; frame_len = 8'd0;
        push_frame(0, -1);
        run(5000);
        idle_chk(2);

        // single zero byte
        pl_buf[0] = 8'h00;
        start = 1'b1; frame_len = 8'd1;
        push_frame(1, -1);
        run(5000);
        idle_chk(2);

        // three bytes
        pl_buf[0] = 8'hA5; pl_buf[1] = 8'h3C; pl_buf[2] = 8'hFF;
        start = 1'b1; frame_len = 8'd3;
        push_frame(3, -1);
        run(5000);
        idle_chk(2);

        // second byte withheld
        pl_buf[0] = 8'h11; pl_buf[1] = 8'h22;
        start = 1'b1; frame_len = 8'd2;
        push_frame(2, 1);
        run(5000);
        idle_chk(3);

        // start held high: back-to-back frames
        hold = 1'b1; start = 1'b1; frame_len = 8'd1;
        pl_buf[0] = 8'h5A; push_frame(1, -1);
        pl_buf[0] = 8'hC3; push_frame(1, -1);
        pl_buf[0] = 8'h80; push_frame(1, -1);
        run(5000);
        hold = 1'b0;
        idle_chk(2);

        // reset in the middle of the payload
        pl_buf[0] = 8'h01; pl_buf[1] = 8'hFE; pl_buf[2] = 8'h77;
        start = 1'b1; frame_len = 8'd3;
        push_frame(3, -1);
        run(P + 16 + 12);
        exp_q.delete();
        pay_q.delete();
        reset = 1'b1;
        @(negedge clk);
        cyc++;
        chk("reset_mid_frame", 32'(outs()), 32'd0);
        $display("reset asserted mid-payload");
        reset = 1'b0;
        idle_chk(2);

        pl_buf[0] = 8'h9B; pl_buf[1] = 8'h40;
        start = 1'b1; frame_len = 8'd2;
        push_frame(2, -1);
        run(5000);
        idle_chk(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
